// File: rtl/alu_ex_if.sv
// ---------------------------------------------------------------------------
// alu_ex_if
// Handshake and data bundle between the decode stage (master) and the
// execute-stage ALU (slave).
//   in_valid  master->slave  op/a/b are valid this cycle
//   in_ready  slave->master  ALU can accept an op this cycle
//   op        master->slave  4-bit operation code
//   a, b      master->slave  operands (b doubles as the shift amount)
//   flush     master->slave  kill the in-flight op
//   out_valid slave->master  one-cycle pulse, result/flags updated
//   result    slave->master  registered result
//   flag_z/v/c/n slave->master  zero, overflow, carry, negative flags
//   busy      slave->master  iterative multiply in progress
// ---------------------------------------------------------------------------
interface alu_ex_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_v;
  logic             flag_c;
  logic             flag_n;
  logic             busy;

  modport master (
    output in_valid, op, a, b, flush,
    input  in_ready, out_valid, result, flag_z, flag_v, flag_c, flag_n, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush,
    output in_ready, out_valid, result, flag_z, flag_v, flag_c, flag_n, busy
  );

endinterface

// File: rtl/alu_ex_stage.sv
// ---------------------------------------------------------------------------
// alu_ex_stage
// Execute-stage ALU with valid/ready handshake, registered result and
// Z/V/C/N flags, arithmetic right shift and an iterative shift-add multiplier.
// Single-cycle ops complete on the accept edge; MUL takes WIDTH step edges
// and holds in_ready low meanwhile.
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   s_alu    alu_ex_if slave modport (handshake, operands, result, flags)
// Parameters:
//   WIDTH    datapath width (>= 4)
//   MUL_EN   1 builds the multiplier, 0 makes opcode 1011 an illegal op
// ---------------------------------------------------------------------------
module alu_ex_stage #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic     i_clk,
  input logic     i_rst_n,
  alu_ex_if.slave s_alu
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_PASSB = 4'b0010;
  localparam logic [3:0] OP_PASSA = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOTB  = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_result;
  logic               r_flagZ;
  logic               r_flagV;
  logic               r_flagC;
  logic               r_flagN;
  logic               r_outValid;
  logic [2*WIDTH-1:0] r_mulA;
  logic [WIDTH-1:0]   r_mulB;
  logic [2*WIDTH-1:0] r_mulAcc;
  logic [CW-1:0]      r_count;

  logic               w_inReady;
  logic               w_accept;
  logic               w_isMul;
  logic               w_isSub;
  logic [WIDTH-1:0]   w_addB;
  logic [WIDTH:0]     w_sum;
  logic               w_bigShift;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_aluResult;
  logic               w_aluV;
  logic               w_aluC;
  logic [2*WIDTH-1:0] w_mulNext;
  logic               w_mulLast;

  assign w_inReady = (r_state == S_IDLE) && !s_alu.flush;
  assign w_accept  = s_alu.in_valid && w_inReady;
  assign w_isMul   = (s_alu.op == OP_MUL) && (MUL_EN == 1'b1);

  // SUB shares the adder as a + ~b + 1 so the carry-out is the "no borrow" bit.
  assign w_isSub = (s_alu.op == OP_SUB);
  assign w_addB  = w_isSub ? ~s_alu.b : s_alu.b;
  assign w_sum   = {1'b0, s_alu.a} + {1'b0, w_addB} + {{WIDTH{1'b0}}, w_isSub};

  // Any shift amount of WIDTH or more saturates instead of wrapping.
  assign w_bigShift = (s_alu.b >= WIDTH'(WIDTH));
  assign w_shamt    = s_alu.b[SHW-1:0];

  // Single-cycle datapath; illegal opcodes (and MUL when not built) give 0.
  always_comb begin
    w_aluResult = '0;
    w_aluV      = 1'b0;
    w_aluC      = 1'b0;
    case (s_alu.op)
      OP_ADD, OP_SUB: begin
        w_aluResult = w_sum[WIDTH-1:0];
        w_aluC      = w_sum[WIDTH];
        w_aluV      = (s_alu.a[WIDTH-1] == w_addB[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != s_alu.a[WIDTH-1]);
      end
      OP_PASSB: w_aluResult = s_alu.b;
      OP_PASSA: w_aluResult = s_alu.a;
      OP_AND:   w_aluResult = s_alu.a & s_alu.b;
      OP_OR:    w_aluResult = s_alu.a | s_alu.b;
      OP_XOR:   w_aluResult = s_alu.a ^ s_alu.b;
      OP_NOTB:  w_aluResult = ~s_alu.b;
      OP_SLL:   w_aluResult = w_bigShift ? '0 : (s_alu.a << w_shamt);
      OP_SRL:   w_aluResult = w_bigShift ? '0 : (s_alu.a >> w_shamt);
      OP_SRA:   w_aluResult = w_bigShift ? {WIDTH{s_alu.a[WIDTH-1]}}
                                         : WIDTH'($signed(s_alu.a) >>> w_shamt);
      default:  w_aluResult = '0;
    endcase
  end

  // One multiplier bit per step: r_mulA is shifted left and r_mulB right, so
  // the current LSB of r_mulB always selects the correctly weighted addend.
  assign w_mulNext = r_mulAcc + (r_mulB[0] ? r_mulA : '0);
  assign w_mulLast = (r_count == CW'(WIDTH - 1));

  // Control FSM plus all registered outputs. out_valid defaults low so it is
  // only ever a single-cycle pulse; flush in S_MUL takes priority over the
  // final step so an aborted multiply never updates result or flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_flagZ    <= 1'b0;
      r_flagV    <= 1'b0;
      r_flagC    <= 1'b0;
      r_flagN    <= 1'b0;
      r_outValid <= 1'b0;
      r_mulA     <= '0;
      r_mulB     <= '0;
      r_mulAcc   <= '0;
      r_count    <= '0;
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_isMul) begin
              r_state  <= S_MUL;
              r_mulA   <= {{WIDTH{1'b0}}, s_alu.a};
              r_mulB   <= s_alu.b;
              r_mulAcc <= '0;
              r_count  <= '0;
            end else begin
              r_result   <= w_aluResult;
              r_flagZ    <= (w_aluResult == '0);
              r_flagV    <= w_aluV;
              r_flagC    <= w_aluC;
              r_flagN    <= w_aluResult[WIDTH-1];
              r_outValid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (s_alu.flush) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else begin
            r_mulAcc <= w_mulNext;
            r_mulA   <= r_mulA << 1;
            r_mulB   <= r_mulB >> 1;
            r_count  <= r_count + 1'b1;
            if (w_mulLast) begin
              r_state    <= S_IDLE;
              r_count    <= '0;
              r_result   <= w_mulNext[WIDTH-1:0];
              r_flagZ    <= (w_mulNext[WIDTH-1:0] == '0);
              r_flagV    <= |w_mulNext[2*WIDTH-1:WIDTH];
              r_flagC    <= 1'b0;
              r_flagN    <= w_mulNext[WIDTH-1];
              r_outValid <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_alu.in_ready  = w_inReady;
  assign s_alu.out_valid = r_outValid;
  assign s_alu.result    = r_result;
  assign s_alu.flag_z    = r_flagZ;
  assign s_alu.flag_v    = r_flagV;
  assign s_alu.flag_c    = r_flagC;
  assign s_alu.flag_n    = r_flagN;
  assign s_alu.busy      = (r_state == S_MUL);

endmodule

// File: tb/tb_alu_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_ex_stage
// Directed self-checking bench for alu_ex_stage (WIDTH=16, MUL_EN=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_alu_ex_stage;

  logic clk;
  logic rstN;
  int   checks;
  int   failures;

  alu_ex_if #(.WIDTH(16)) bus ();

  alu_ex_stage #(
    .WIDTH (16),
    .MUL_EN(1'b1)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .s_alu  (bus)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;

  // Flags are packed as {Z, V, C, N}.
  vec_t vecs [18] = '{
    '{4'h1, 16'h0005, 16'h0005, 16'h0000, 4'b1010},
    '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010},
    '{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0001},
    '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0110},
    '{4'hA, 16'h8000, 16'h0003, 16'hF000, 4'b0001},
    '{4'hA, 16'h8000, 16'h0014, 16'hFFFF, 4'b0001},
    '{4'h9, 16'h8000, 16'h0014, 16'h0000, 4'b1000},
    '{4'h9, 16'h8000, 16'h000F, 16'h0001, 4'b0000},
    '{4'h8, 16'h0001, 16'h0004, 16'h0010, 4'b0000},
    '{4'h8, 16'h0001, 16'h0010, 16'h0000, 4'b1000},
    '{4'hA, 16'h4000, 16'h0014, 16'h0000, 4'b1000},
    '{4'hA, 16'h8000, 16'h000F, 16'hFFFF, 4'b0001},
    '{4'h2, 16'hF0F0, 16'hFF00, 16'hFF00, 4'b0001},
    '{4'h3, 16'hF0F0, 16'hFF00, 16'hF0F0, 4'b0001},
    '{4'h4, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0001},
    '{4'h5, 16'hF0F0, 16'hFF00, 16'hFFF0, 4'b0001},
    '{4'h6, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000},
    '{4'h7, 16'hF0F0, 16'hFF00, 16'h00FF, 4'b0000}
  };

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] op,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic flush);
    bus.in_valid = valid;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.flush    = flush;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] obsFlags();
    return {bus.flag_z, bus.flag_v, bus.flag_c, bus.flag_n};
  endfunction

  task automatic checkResult(input string tag, input logic [15:0] expRes,
                             input logic [3:0] expFlags);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_result"}, 32'(bus.result), 32'(expRes));
    checkOutput({tag, "_flags"}, 32'(obsFlags()), 32'(expFlags));
  endtask

  initial begin
    logic sawValid;
    checks   = 0;
    failures = 0;
    rstN     = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 4'h0;
    bus.a        = 16'h0;
    bus.b        = 16'h0;
    bus.flush    = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_result", 32'(bus.result), 32'h0);
    checkOutput("rst_flags", 32'(obsFlags()), 32'h0);
    checkOutput("rst_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rstN = 1'b1;
    nextCycle();

    // ADD with signed overflow, one-cycle latency, then result holds
    applyStimulus(1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b0);
    checkOutput("add_ovf_ready", 32'(bus.in_ready), 32'h1);
    nextCycle();
    checkResult("add_ovf", 16'h8000, 4'b0101);
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    nextCycle();
    checkOutput("add_ovf_pulse_end", 32'(bus.out_valid), 32'h0);
    checkOutput("add_ovf_hold", 32'(bus.result), 32'h8000);

    // Back-to-back table of single-cycle ops
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      checkOutput($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'h1);
      nextCycle();
      checkResult($sformatf("vec%0d", i), vecs[i].res, vecs[i].fl);
    end
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    nextCycle();

    // MUL 0x0123 * 0x0010 with per-cycle stall checks
    applyStimulus(1'b1, 4'hB, 16'h0123, 16'h0010, 1'b0);
    checkOutput("mul1_ready", 32'(bus.in_ready), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("mul1_busy", 32'(bus.busy), 32'h1);
    checkOutput("mul1_stall_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("mul1_stall_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 2; i <= 16; i++) begin
      nextCycle();
      checkOutput($sformatf("mul1_wait%0d_valid", i), 32'(bus.out_valid), 32'h0);
      checkOutput($sformatf("mul1_wait%0d_ready", i), 32'(bus.in_ready), 32'h0);
    end
    nextCycle();
    checkResult("mul1", 16'h1230, 4'b0000);
    checkOutput("mul1_done_ready", 32'(bus.in_ready), 32'h1);
    checkOutput("mul1_done_busy", 32'(bus.busy), 32'h0);

    // MUL 0x0100 * 0x0100: product overflows the low half
    applyStimulus(1'b1, 4'hB, 16'h0100, 16'h0100, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    repeat (16) nextCycle();
    checkResult("mul2", 16'h0000, 4'b1100);

    // Known result before the flush test
    applyStimulus(1'b1, 4'h0, 16'h1234, 16'h0001, 1'b0);
    nextCycle();
    checkResult("add_pre_flush", 16'h1235, 4'b0000);

    // Flush during MUL step 5
    applyStimulus(1'b1, 4'hB, 16'h0003, 16'h0003, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    repeat (4) nextCycle();
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1);
    checkOutput("flush_mul_ready_low", 32'(bus.in_ready), 32'h0);
    checkOutput("flush_mul_busy", 32'(bus.busy), 32'h1);
    nextCycle();
    checkOutput("flush_mul_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("flush_mul_idle", 32'(bus.busy), 32'h0);
    checkOutput("flush_mul_result", 32'(bus.result), 32'h1235);
    checkOutput("flush_mul_flags", 32'(obsFlags()), 32'h0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("flush_mul_ready_next", 32'(bus.in_ready), 32'h1);
    sawValid = 1'b0;
    repeat (16) begin
      nextCycle();
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("flush_mul_no_late_valid", 32'(sawValid), 32'h0);

    // Flush in IDLE blocks a simultaneous valid op
    applyStimulus(1'b1, 4'h0, 16'h0001, 16'h0001, 1'b1);
    checkOutput("flush_idle_ready", 32'(bus.in_ready), 32'h0);
    nextCycle();
    checkOutput("flush_idle_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("flush_idle_result", 32'(bus.result), 32'h1235);
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    nextCycle();

    // Asynchronous reset in the middle of a MUL
    applyStimulus(1'b1, 4'hB, 16'h0003, 16'h0005, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    repeat (3) nextCycle();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst_mid_result", 32'(bus.result), 32'h0);
    checkOutput("rst_mid_flags", 32'(obsFlags()), 32'h0);
    checkOutput("rst_mid_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_mid_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_mid_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rstN = 1'b1;
    sawValid = 1'b0;
    repeat (20) begin
      nextCycle();
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("rst_mid_no_valid", 32'(sawValid), 32'h0);
    checkOutput("rst_mid_result_after", 32'(bus.result), 32'h0);

    // Four back-to-back ADDs followed by an illegal opcode
    applyStimulus(1'b1, 4'h0, 16'h0001, 16'h0002, 1'b0);
    nextCycle();
    checkResult("b2b_add0", 16'h0003, 4'b0000);
    applyStimulus(1'b1, 4'h0, 16'h00FF, 16'h0001, 1'b0);
    checkOutput("b2b_ready1", 32'(bus.in_ready), 32'h1);
    nextCycle();
    checkResult("b2b_add1", 16'h0100, 4'b0000);
    applyStimulus(1'b1, 4'h0, 16'h8000, 16'h8000, 1'b0);
    nextCycle();
    checkResult("b2b_add2", 16'h0000, 4'b1110);
    applyStimulus(1'b1, 4'h0, 16'h1000, 16'h0234, 1'b0);
    nextCycle();
    checkResult("b2b_add3", 16'h1234, 4'b0000);
    applyStimulus(1'b1, 4'hD, 16'h0005, 16'h0005, 1'b0);
    checkOutput("b2b_ready4", 32'(bus.in_ready), 32'h1);
    nextCycle();
    checkResult("b2b_illegal", 16'h0000, 4'b1000);
    applyStimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    nextCycle();
    checkOutput("b2b_end_valid", 32'(bus.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
